pp_merge_78: RTL and testbench



---
 rtl/pp_merge_78.sv | 129 ++++++++++++
 tb/tb_pp_merge_78.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pp_merge_78.sv
// Sliced carry-propagate merge of two partial-sum vectors into a W+1 bit result.
// Optional accumulate mode is enabled by defining PP_MERGE_ACC_EN.
module pp_merge_78 #(
  parameter int SIZE   = 3072,
  parameter int RADIX  = 78,
  parameter int CHUNKS = 8,
  localparam int W     = SIZE + RADIX + 2,
  localparam int CW    = W / CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_in,
  input  logic [W-1:0] r0,
  input  logic [W-1:0] r1,
  input  logic         acc_clr,
  output logic [W:0]   sum,
  output logic         valid,
  output logic         busy,
  output logic         drop,
  output logic         ovf
);

  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    op0, op1;
  logic [1:0]      carry;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   acc_slice;
  logic [CW+1:0]   slice_tot;
  logic [1:0]      top_tot;

  // Three CW-bit terms plus a 2-bit carry never exceed CW+2 bits.
  function automatic logic [CW+1:0] slice_add(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b,
                                              input logic [CW-1:0] c,
                                              input logic [1:0]    ci);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {{CW{1'b0}}, ci};
  endfunction

`ifdef PP_MERGE_ACC_EN
  logic acc_on;

  always_comb begin
    acc_slice = '0;
    if (acc_on) acc_slice = sum[idx*CW +: CW];
    slice_tot = slice_add(op0[idx*CW +: CW], op1[idx*CW +: CW], acc_slice, carry);
    // Old top bit joins the final carry so the whole W+1 bit sum wraps.
    top_tot   = slice_tot[CW+1:CW] + {1'b0, acc_on & sum[W]};
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;

  always_comb begin
    acc_slice = '0;
    slice_tot = slice_add(op0[idx*CW +: CW], op1[idx*CW +: CW], acc_slice, carry);
    top_tot   = slice_tot[CW+1:CW];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (en_in) state_nxt = ADD;
      ADD: begin
        busy = 1'b1;
        drop = en_in;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        drop      = en_in;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum    <= '0;
      op0    <= '0;
      op1    <= '0;
      carry  <= '0;
      idx    <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
`ifdef PP_MERGE_ACC_EN
      acc_on <= 1'b0;
`endif
    end else begin
      valid <= (state == DONE);
      case (state)
        IDLE: if (en_in) begin
          op0    <= r0;
          op1    <= r1;
          idx    <= '0;
          carry  <= '0;
`ifdef PP_MERGE_ACC_EN
          acc_on <= ~acc_clr;
`endif
        end
        ADD: begin
          sum[idx*CW +: CW] <= slice_tot[CW-1:0];
          carry             <= slice_tot[CW+1:CW];
          idx               <= idx + 1'b1;
          if (idx == LAST) begin
            sum[W] <= top_tot[0];
            idx    <= '0;
            if (top_tot[1]) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_merge_78.sv
// Directed self-checking bench for pp_merge_78 at default parameters.
// Accumulator scenarios are compiled in when PP_MERGE_ACC_EN is defined.
module tb_pp_merge_78;

  localparam int W = 3152;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_in;
  logic [W-1:0] r0, r1;
  logic         acc_clr;
  logic [W:0]   sum;
  logic         valid, busy, drop, ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  pp_merge_78 dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .r0(r0), .r1(r1), .acc_clr(acc_clr),
    .sum(sum), .valid(valid), .busy(busy), .drop(drop), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Returns at the falling edge right after the edge that sampled en_in.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic clr);
    r0 = a; r1 = b; acc_clr = clr; en_in = 1'b1;
    @(negedge clk);
    en_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en_in = 1'b0; r0 = '0; r1 = '0; acc_clr = 1'b0;
    #12;
    n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got low=%0h want 0", sum[63:0]); end
    n_cmp++; if ({valid, busy, drop, ovf} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {valid, busy, drop, ovf}); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcnt;
    start(5, 7, 1'b1);
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++; if (bcnt !== 9) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 9", bcnt); end
    n_cmp++; if (sum !== (W+1)'(12)) begin n_fail++; $display("FAIL basic_sum: got low=%0h want c", sum[63:0]); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width: got %b want 0", valid); end
  endtask

  task automatic test_ripple;
    int lat, bcnt;
    logic [W:0] exp;
    exp = '0; exp[W] = 1'b1;
    start('1, 1, 1'b1);
    wait_valid(lat, bcnt);
    n_cmp++; if (sum !== exp) begin n_fail++; $display("FAIL ripple_sum: got top=%b ones=%0d want top=1 ones=1", sum[W], $countones(sum)); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ripple_ovf: got %b want 0", ovf); end
    @(negedge clk);
  endtask

  task automatic test_drop;
    int dcnt, vcnt;
    logic [W:0] got;
    dcnt = 0; vcnt = 0; got = '0;
    start(100, 23, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      en_in = (i == 3);
      r0 = (i == 3) ? W'(999) : W'(0);
      #1;
      if (drop) dcnt++;
      if (valid) begin vcnt++; got = sum; end
    end
    en_in = 1'b0;
    n_cmp++; if (dcnt !== 1) begin n_fail++; $display("FAIL drop_count: got %0d want 1", dcnt); end
    n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL drop_valid_count: got %0d want 1", vcnt); end
    n_cmp++; if (got !== (W+1)'(123)) begin n_fail++; $display("FAIL drop_sum: got low=%0h want 7b", got[63:0]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    start(1, 1, 1'b1);
    wait_valid(lat, bcnt);
    start(3, 4, 1'b1);
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_latency: got %0d want 9", lat); end
    n_cmp++; if (sum !== (W+1)'(7)) begin n_fail++; $display("FAIL b2b_sum: got low=%0h want 7", sum[63:0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, vcnt;
    vcnt = 0;
    start(50, 60, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL midrst_sum: got low=%0h want 0", sum[63:0]); end
    n_cmp++; if ({valid, busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: got %b want 00", {valid, busy}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (15) begin @(negedge clk); if (valid) vcnt++; end
    n_cmp++; if (vcnt !== 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d want 0", vcnt); end
    start(1, 2, 1'b1);
    wait_valid(lat, bcnt);
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL midrst_latency: got %0d want 9", lat); end
    n_cmp++; if (sum !== (W+1)'(3)) begin n_fail++; $display("FAIL midrst_sum_after: got low=%0h want 3", sum[63:0]); end
    @(negedge clk);
  endtask

`ifdef PP_MERGE_ACC_EN
  task automatic test_accumulate;
    int lat, bcnt;
    logic [W:0] exp;
    start(10, 20, 1'b1); wait_valid(lat, bcnt);
    n_cmp++; if (sum !== (W+1)'(30)) begin n_fail++; $display("FAIL acc_first: got low=%0h want 1e", sum[63:0]); end
    @(negedge clk);
    start(1, 2, 1'b0); wait_valid(lat, bcnt);
    n_cmp++; if (sum !== (W+1)'(33)) begin n_fail++; $display("FAIL acc_second: got low=%0h want 21", sum[63:0]); end
    @(negedge clk);
    start('1, '1, 1'b1); wait_valid(lat, bcnt); @(negedge clk);
    start(1, 0, 1'b0); wait_valid(lat, bcnt);
    exp = '1;
    n_cmp++; if (sum !== exp) begin n_fail++; $display("FAIL acc_preload: got ones=%0d want %0d", $countones(sum), W+1); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL acc_preload_ovf: got %b want 0", ovf); end
    @(negedge clk);
    start(1, 0, 1'b0); wait_valid(lat, bcnt);
    n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL acc_wrap_sum: got ones=%0d want 0", $countones(sum)); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL acc_wrap_ovf: got %b want 1", ovf); end
    @(negedge clk);
    start(5, 5, 1'b1); wait_valid(lat, bcnt);
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL acc_ovf_sticky: got %b want 1", ovf); end
    @(negedge clk);
  endtask
`else
  task automatic test_no_accumulate;
    int lat, bcnt;
    start(10, 20, 1'b1); wait_valid(lat, bcnt); @(negedge clk);
    start(1, 2, 1'b0); wait_valid(lat, bcnt);
    n_cmp++; if (sum !== (W+1)'(3)) begin n_fail++; $display("FAIL noacc_sum: got low=%0h want 3", sum[63:0]); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL noacc_ovf: got %b want 0", ovf); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_ripple;
    test_drop;
    test_back_to_back;
    test_reset_mid;
`ifdef PP_MERGE_ACC_EN
    test_accumulate;
`else
    test_no_accumulate;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
